model_matrix_stream_transmitter: RTL and testbench

MODEL_MATRIX_STREAM_TRANSMITTER -- requirements
Module: model_matrix_stream_transmitter

---
 rtl/model_matrix_stream_transmitter.sv | 154 +++++++++++++++
 tb/tb_model_matrix_stream_transmitter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/model_matrix_stream_transmitter.sv
// rtl/model_matrix_stream_transmitter.sv - buffered matrix streamer with row/element handshake
//
// Holds a MAX_I x MAX_J element buffer loaded while idle, then streams a
// SIZE_I x SIZE_J sub-matrix in row-major order, one element per consumer
// REQUEST_J_ENABLE.
//
// Ports:
//   CLK, RST                    clock (rising edge), asynchronous active-low reset
//   WRITE_ENABLE/_I/_J/_DATA    buffer write port, honoured only while idle
//   START, SIZE_I_IN, SIZE_J_IN start a transmission of the given size
//   READY                       one-cycle pulse: transmission done or size rejected
//   REQUEST_I_ENABLE            consumer row strobe, ignored
//   REQUEST_J_ENABLE            consumer request for the next element
//   DATA_OUT_I_ENABLE           pulse with the first element of each row
//   DATA_OUT_J_ENABLE           pulse with every element
//   DATA_OUT                    element value, held until the next element
//   SIZE_I_OUT, SIZE_J_OUT      sizes latched at START
module model_matrix_stream_transmitter #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int MAX_I        = 4,
  parameter int MAX_J        = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    WRITE_ENABLE,
  input  logic [CONTROL_SIZE-1:0] WRITE_I,
  input  logic [CONTROL_SIZE-1:0] WRITE_J,
  input  logic [DATA_SIZE-1:0]    WRITE_DATA,
  input  logic                    START,
  output logic                    READY,
  input  logic [DATA_SIZE-1:0]    SIZE_I_IN,
  input  logic [DATA_SIZE-1:0]    SIZE_J_IN,
  input  logic                    REQUEST_I_ENABLE,
  input  logic                    REQUEST_J_ENABLE,
  output logic                    DATA_OUT_I_ENABLE,
  output logic                    DATA_OUT_J_ENABLE,
  output logic [DATA_SIZE-1:0]    DATA_OUT,
  output logic [DATA_SIZE-1:0]    SIZE_I_OUT,
  output logic [DATA_SIZE-1:0]    SIZE_J_OUT
);

  localparam int IW = (MAX_I > 1) ? $clog2(MAX_I) : 1;
  localparam int JW = (MAX_J > 1) ? $clog2(MAX_J) : 1;

  typedef enum logic [1:0] {
    S_STARTER = 2'd0,
    S_EMIT    = 2'd1,
    S_WAIT    = 2'd2
  } state_t;

  state_t                  state;
  logic [DATA_SIZE-1:0]    buffer [MAX_I][MAX_J];
  logic [CONTROL_SIZE-1:0] idx_i;
  logic [CONTROL_SIZE-1:0] idx_j;

  // Row strobe carries no information the element count does not already give.
  logic unused_request_i;
  assign unused_request_i = REQUEST_I_ENABLE;

  logic          write_in_range;
  logic          size_ok;
  logic          last_i;
  logic          last_j;
  logic [IW-1:0] write_row;
  logic [JW-1:0] write_col;
  logic [IW-1:0] read_row;
  logic [JW-1:0] read_col;

  // Range checks use the full-width indices so out-of-range writes cannot
  // alias onto a valid entry through the truncated address.
  assign write_in_range = (WRITE_I < CONTROL_SIZE'(MAX_I)) && (WRITE_J < CONTROL_SIZE'(MAX_J));
  assign write_row      = WRITE_I[IW-1:0];
  assign write_col      = WRITE_J[JW-1:0];
  assign read_row       = idx_i[IW-1:0];
  assign read_col       = idx_j[JW-1:0];

  assign size_ok = (SIZE_I_IN != '0) && (SIZE_I_IN <= DATA_SIZE'(MAX_I)) &&
                   (SIZE_J_IN != '0) && (SIZE_J_IN <= DATA_SIZE'(MAX_J));

  assign last_i = (idx_i == CONTROL_SIZE'(SIZE_I_OUT - 1'b1));
  assign last_j = (idx_j == CONTROL_SIZE'(SIZE_J_OUT - 1'b1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state             <= S_STARTER;
      READY             <= 1'b0;
      DATA_OUT_I_ENABLE <= 1'b0;
      DATA_OUT_J_ENABLE <= 1'b0;
      DATA_OUT          <= '0;
      SIZE_I_OUT        <= '0;
      SIZE_J_OUT        <= '0;
      idx_i             <= '0;
      idx_j             <= '0;
      for (int r = 0; r < MAX_I; r++) begin
        for (int c = 0; c < MAX_J; c++) begin
          buffer[r][c] <= '0;
        end
      end
    end else begin
      // Pulses default low; each state raises only what it owns.
      READY             <= 1'b0;
      DATA_OUT_I_ENABLE <= 1'b0;
      DATA_OUT_J_ENABLE <= 1'b0;

      case (state)
        S_STARTER: begin
          // The buffer is read no earlier than EMIT, so a write landing on
          // the START edge is already visible to the first element.
          if (WRITE_ENABLE && write_in_range) begin
            buffer[write_row][write_col] <= WRITE_DATA;
          end
          if (START) begin
            if (size_ok) begin
              SIZE_I_OUT <= SIZE_I_IN;
              SIZE_J_OUT <= SIZE_J_IN;
              idx_i      <= '0;
              idx_j      <= '0;
              state      <= S_EMIT;
            end else begin
              READY <= 1'b1;
            end
          end
        end

        S_EMIT: begin
          DATA_OUT          <= buffer[read_row][read_col];
          DATA_OUT_J_ENABLE <= 1'b1;
          DATA_OUT_I_ENABLE <= (idx_j == '0);
          state             <= S_WAIT;
        end

        S_WAIT: begin
          if (REQUEST_J_ENABLE) begin
            if (last_i && last_j) begin
              READY <= 1'b1;
              state <= S_STARTER;
            end else if (last_j) begin
              idx_i <= idx_i + 1'b1;
              idx_j <= '0;
              state <= S_EMIT;
            end else begin
              idx_j <= idx_j + 1'b1;
              state <= S_EMIT;
            end
          end
        end

        default: state <= S_STARTER;
      endcase
    end
  end

endmodule

// File: tb/tb_model_matrix_stream_transmitter.sv
// tb/tb_model_matrix_stream_transmitter.sv - self-checking bench for model_matrix_stream_transmitter
module tb_model_matrix_stream_transmitter;

  localparam int MI = 4;
  localparam int MJ = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        WRITE_ENABLE;
  logic [63:0] WRITE_I;
  logic [63:0] WRITE_J;
  logic [63:0] WRITE_DATA;
  logic        START;
  logic        READY;
  logic [63:0] SIZE_I_IN;
  logic [63:0] SIZE_J_IN;
  logic        REQUEST_I_ENABLE;
  logic        REQUEST_J_ENABLE;
  logic        DATA_OUT_I_ENABLE;
  logic        DATA_OUT_J_ENABLE;
  logic [63:0] DATA_OUT;
  logic [63:0] SIZE_I_OUT;
  logic [63:0] SIZE_J_OUT;

  model_matrix_stream_transmitter #(
    .DATA_SIZE(64), .CONTROL_SIZE(64), .MAX_I(MI), .MAX_J(MJ)
  ) dut (
    .CLK(CLK), .RST(RST),
    .WRITE_ENABLE(WRITE_ENABLE), .WRITE_I(WRITE_I), .WRITE_J(WRITE_J), .WRITE_DATA(WRITE_DATA),
    .START(START), .READY(READY), .SIZE_I_IN(SIZE_I_IN), .SIZE_J_IN(SIZE_J_IN),
    .REQUEST_I_ENABLE(REQUEST_I_ENABLE), .REQUEST_J_ENABLE(REQUEST_J_ENABLE),
    .DATA_OUT_I_ENABLE(DATA_OUT_I_ENABLE), .DATA_OUT_J_ENABLE(DATA_OUT_J_ENABLE),
    .DATA_OUT(DATA_OUT), .SIZE_I_OUT(SIZE_I_OUT), .SIZE_J_OUT(SIZE_J_OUT)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference image of what the buffer should hold.
  logic [63:0] ref_buf [MI][MJ];

  typedef struct {
    int si;
    int sj;
    int dly;
    bit reject;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    WRITE_ENABLE     = 1'b0;
    START            = 1'b0;
    REQUEST_I_ENABLE = 1'b0;
    REQUEST_J_ENABLE = 1'b0;
  endtask

  task automatic clear_model();
    for (int r = 0; r < MI; r++)
      for (int c = 0; c < MJ; c++)
        ref_buf[r][c] = '0;
  endtask

  task automatic wr(input int r, input int c, input logic [63:0] d);
    WRITE_ENABLE = 1'b1;
    WRITE_I      = 64'(r);
    WRITE_J      = 64'(c);
    WRITE_DATA   = d;
    step();
    WRITE_ENABLE = 1'b0;
    if (r < MI && c < MJ) ref_buf[r][c] = d;
  endtask

  task automatic fill_random();
    for (int r = 0; r < MI; r++)
      for (int c = 0; c < MJ; c++)
        wr(r, c, {$urandom, $urandom});
  endtask

  // Drives one transmission and checks every element against the reference
  // image in row-major order. dly<0 picks a random response delay per
  // element; abort_after>0 returns right after that many elements are seen.
  task automatic run_tx(input int si, input int sj, input int dly, input bit reject,
                        input int abort_after, input bit co_we, input logic [63:0] co_data);
    int          n;
    int          ipulses;
    int          wait_cnt;
    int          d;
    bit          last;
    logic [63:0] exp_v;
    n       = 0;
    ipulses = 0;
    START     = 1'b1;
    SIZE_I_IN = 64'(si);
    SIZE_J_IN = 64'(sj);
    if (co_we) begin
      WRITE_ENABLE = 1'b1;
      WRITE_I      = '0;
      WRITE_J      = '0;
      WRITE_DATA   = co_data;
      ref_buf[0][0] = co_data;
    end
    step();
    START        = 1'b0;
    WRITE_ENABLE = 1'b0;
    SIZE_I_IN    = 64'($urandom);
    SIZE_J_IN    = 64'($urandom);
    if (reject) begin
      check("reject_ready", READY, 1'b1);
      check("reject_enables", {DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE}, 2'b00);
      for (int k = 0; k < 4; k++) begin
        step();
        check("reject_quiet", {READY, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE}, 3'b000);
      end
      return;
    end
    check("size_i_out", SIZE_I_OUT, 64'(si));
    check("size_j_out", SIZE_J_OUT, 64'(sj));
    check("start_no_ready", READY, 1'b0);
    for (int i = 0; i < si; i++) begin
      for (int j = 0; j < sj; j++) begin
        exp_v    = ref_buf[i][j];
        wait_cnt = 0;
        while (!DATA_OUT_J_ENABLE && wait_cnt < 8) begin
          step();
          wait_cnt++;
        end
        check("pulse_latency", 64'(wait_cnt), 64'd1);
        if (!DATA_OUT_J_ENABLE) return;
        check("data_out", DATA_OUT, exp_v);
        check("i_enable", DATA_OUT_I_ENABLE, (j == 0));
        check("ready_mid", READY, 1'b0);
        ipulses += int'(DATA_OUT_I_ENABLE);
        n++;
        if (n == abort_after) return;
        d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
        for (int k = 0; k < d; k++) begin
          // Noise the block must ignore while streaming.
          REQUEST_I_ENABLE = 1'($urandom);
          START            = 1'($urandom);
          WRITE_ENABLE     = 1'b1;
          WRITE_I          = 64'($urandom_range(0, 3));
          WRITE_J          = 64'($urandom_range(0, 3));
          WRITE_DATA       = {$urandom, $urandom};
          SIZE_I_IN        = 64'($urandom_range(0, 6));
          SIZE_J_IN        = 64'($urandom_range(0, 6));
          step();
          check("hold_quiet", {READY, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE}, 3'b000);
          check("hold_data", DATA_OUT, exp_v);
          check("hold_size_i", SIZE_I_OUT, 64'(si));
        end
        idle_inputs();
        REQUEST_J_ENABLE = 1'b1;
        step();
        REQUEST_J_ENABLE = 1'b0;
        last = (i == si - 1) && (j == sj - 1);
        check("ready_after_req", READY, last);
        check("enables_after_req", {DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE}, 2'b00);
      end
    end
    check("i_pulse_count", 64'(ipulses), 64'(si));
    check("j_pulse_count", 64'(n), 64'(si * sj));
    step();
    check("ready_single", READY, 1'b0);
  endtask

  vec_t vecs [9];

  initial begin
    vecs[0] = '{si: 2, sj: 2, dly: -1, reject: 1'b0};
    vecs[1] = '{si: 0, sj: 2, dly:  0, reject: 1'b1};
    vecs[2] = '{si: 5, sj: 1, dly:  0, reject: 1'b1};
    vecs[3] = '{si: 1, sj: 3, dly:  0, reject: 1'b0};
    vecs[4] = '{si: 4, sj: 4, dly: -1, reject: 1'b0};
    vecs[5] = '{si: 2, sj: 0, dly:  0, reject: 1'b1};
    vecs[6] = '{si: 1, sj: 5, dly:  0, reject: 1'b1};
    vecs[7] = '{si: 4, sj: 1, dly:  2, reject: 1'b0};
    vecs[8] = '{si: 3, sj: 4, dly: -1, reject: 1'b0};

    RST = 1'b0;
    idle_inputs();
    WRITE_I = '0; WRITE_J = '0; WRITE_DATA = '0;
    SIZE_I_IN = '0; SIZE_J_IN = '0;
    clear_model();
    repeat (2) @(posedge CLK);
    #1;
    check("reset_ready", READY, 1'b0);
    check("reset_enables", {DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE}, 2'b00);
    check("reset_data", DATA_OUT, 64'd0);
    check("reset_size_i", SIZE_I_OUT, 64'd0);
    check("reset_size_j", SIZE_J_OUT, 64'd0);
    RST = 1'b1;
    step();

    // 2x2 {1,2;3,4}, consumer answers after 3 cycles.
    wr(0, 0, 64'd1); wr(0, 1, 64'd2); wr(1, 0, 64'd3); wr(1, 1, 64'd4);
    run_tx(2, 2, 3, 1'b0, 0, 1'b0, 64'd0);

    // Invalid sizes.
    run_tx(0, 2, 0, 1'b1, 0, 1'b0, 64'd0);
    run_tx(5, 2, 0, 1'b1, 0, 1'b0, 64'd0);

    // 1x3 row {7,8,9}.
    wr(0, 0, 64'd7); wr(0, 1, 64'd8); wr(0, 2, 64'd9);
    run_tx(1, 3, 1, 1'b0, 0, 1'b0, 64'd0);

    // Out-of-range writes ignored; streaming with noise writes and STARTs.
    wr(4, 0, 64'hFF); wr(0, 4, 64'hEE); wr(7, 3, 64'hDD);
    run_tx(4, 4, -1, 1'b0, 0, 1'b0, 64'd0);

    for (int v = 0; v < 9; v++) begin
      fill_random();
      run_tx(vecs[v].si, vecs[v].sj, vecs[v].dly, vecs[v].reject, 0, 1'b0, 64'd0);
    end

    // Write and START on the same edge.
    run_tx(2, 2, 0, 1'b0, 0, 1'b1, 64'hAB);

    // Reset while waiting after the second element.
    fill_random();
    run_tx(2, 2, 1, 1'b0, 2, 1'b0, 64'd0);
    #2;
    RST = 1'b0;
    #1;
    check("async_rst_enables", {READY, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE}, 3'b000);
    check("async_rst_data", DATA_OUT, 64'd0);
    check("async_rst_size", {SIZE_I_OUT, SIZE_J_OUT}, 128'd0);
    clear_model();
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      step();
      check("rst_no_ready", READY, 1'b0);
    end
    RST = 1'b1;
    step();
    check("post_rst_ready", READY, 1'b0);
    run_tx(2, 2, -1, 1'b0, 0, 1'b0, 64'd0);
    wr(3, 3, 64'h55);
    run_tx(4, 4, 0, 1'b0, 0, 1'b0, 64'd0);

    // Random sizes, including invalid ones, against the reference image.
    for (int t = 0; t < 12; t++) begin
      int si;
      int sj;
      si = int'($urandom_range(0, 5));
      sj = int'($urandom_range(0, 5));
      wr(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), {$urandom, $urandom});
      run_tx(si, sj, -1, !(si >= 1 && si <= MI && sj >= 1 && sj <= MJ), 0, 1'($urandom), {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
